// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: opcode encodings and FSM states.
package exec_pkg;

    localparam int OPC_W = 7;

    localparam logic [OPC_W-1:0] OP_ADD = 7'h00;
    localparam logic [OPC_W-1:0] OP_SUB = 7'h01;
    localparam logic [OPC_W-1:0] OP_MUL = 7'h02;
    localparam logic [OPC_W-1:0] OP_NOP = 7'h3F;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } exec_state_t;

endpackage

// File: rtl/mul_pipe.sv
// Registered multiply shift pipeline. The product is formed into the first
// stage and then shifted down MUL_LAT-2 more stages; the execute stage's own
// result register supplies the last cycle, so accept-to-out_valid at the top
// level equals MUL_LAT.
module mul_pipe #(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    output logic [DATA_W-1:0] p
);

    localparam int STAGES = MUL_LAT - 1;

    logic [STAGES-1:0] vld_q;
    logic [DATA_W-1:0] prod_q [STAGES];

    // Shift valid and product down the chain; reset flushes any product in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                prod_q[0] <= a * b;
            end
            for (int i = 1; i < STAGES; i++) begin
                vld_q[i]  <= vld_q[i-1];
                prod_q[i] <= prod_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign p         = prod_q[STAGES-1];

endmodule

// File: rtl/exec_stage_mp.sv
// Execute stage: EX/MEM operand bypass, single-cycle ADD/SUB, blocking
// pipelined MUL with decode back-pressure while the multiply is in flight.
//
//   state       | meaning
//   ------------+-------------------------------------------------------
//   ST_IDLE     | ready for a new instruction; ADD/SUB/illegal retire next cycle
//   ST_MUL_BUSY | multiply in flight, decode stalled, cnt tracks progress
module exec_stage_mp
    import exec_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int MUL_LAT = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [REG_W-1:0]  dst_in,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic [REG_W-1:0]  src1_reg,
    input  logic [REG_W-1:0]  src2_reg,
    input  logic              bp_valid,
    input  logic [REG_W-1:0]  bp_reg,
    input  logic [DATA_W-1:0] bp_data,
    input  logic              bpm_valid,
    input  logic [REG_W-1:0]  bpm_reg,
    input  logic [DATA_W-1:0] bpm_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] result,
    output logic [REG_W-1:0]  dst_out,
    output logic              illegal_op
);

    localparam int               CNT_W    = $clog2(MUL_LAT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

    exec_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic [REG_W-1:0]  mul_dst;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              accept;
    logic              mul_start;
    logic              mul_vld;
    logic [DATA_W-1:0] mul_p;
    logic              mul_done;

    // The result register is written at the completion edge, so a new
    // instruction is only taken once the stage is back in IDLE; this keeps a
    // held ADD from colliding with the multiply's out_valid pulse.
    assign in_ready  = (state == ST_IDLE);
    assign accept    = in_valid & in_ready;
    assign mul_start = accept & (opcode == OP_MUL);
    assign mul_done  = (state == ST_MUL_BUSY) & (cnt == CNT_LAST) & mul_vld;

    // Operand selection: EX bypass wins over MEM bypass; register 0 is never forwarded.
    always_comb begin
        op_a = src1;
        if ((src1_reg != '0) && bp_valid && (bp_reg == src1_reg)) begin
            op_a = bp_data;
        end else if ((src1_reg != '0) && bpm_valid && (bpm_reg == src1_reg)) begin
            op_a = bpm_data;
        end
        op_b = src2;
        if ((src2_reg != '0) && bp_valid && (bp_reg == src2_reg)) begin
            op_b = bp_data;
        end else if ((src2_reg != '0) && bpm_valid && (bpm_reg == src2_reg)) begin
            op_b = bpm_data;
        end
    end

    mul_pipe #(
        .DATA_W  (DATA_W),
        .MUL_LAT (MUL_LAT)
    ) u_mul_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (mul_start),
        .a         (op_a),
        .b         (op_b),
        .out_valid (mul_vld),
        .p         (mul_p)
    );

    // Control FSM with registered result, destination and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            mul_dst    <= '0;
            out_valid  <= 1'b0;
            result     <= '0;
            dst_out    <= '0;
            illegal_op <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            illegal_op <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (opcode)
                            OP_ADD: begin
                                out_valid <= 1'b1;
                                result    <= op_a + op_b;
                                dst_out   <= dst_in;
                            end
                            OP_SUB: begin
                                out_valid <= 1'b1;
                                result    <= op_a - op_b;
                                dst_out   <= dst_in;
                            end
                            OP_MUL: begin
                                state   <= ST_MUL_BUSY;
                                cnt     <= CNT_W'(1);
                                mul_dst <= dst_in;
                            end
                            OP_NOP: begin
                            end
                            default: begin
                                out_valid  <= 1'b1;
                                illegal_op <= 1'b1;
                                result     <= '1;
                                dst_out    <= dst_in;
                            end
                        endcase
                    end
                end
                ST_MUL_BUSY: begin
                    if (mul_done) begin
                        out_valid <= 1'b1;
                        result    <= mul_p;
                        dst_out   <= mul_dst;
                        state     <= ST_IDLE;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_stage_mp.sv
// Bench for exec_stage_mp: directed vector table, hand-written multiply/reset
// sequences, and a randomized run against a cycle-indexed reference model.
module tb_exec_stage_mp;

    localparam int MUL_LAT = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [4:0]  dst_in;
    logic [31:0] src1, src2;
    logic [4:0]  src1_reg, src2_reg;
    logic        bp_valid;
    logic [4:0]  bp_reg;
    logic [31:0] bp_data;
    logic        bpm_valid;
    logic [4:0]  bpm_reg;
    logic [31:0] bpm_data;
    logic        out_valid;
    logic [31:0] result;
    logic [4:0]  dst_out;
    logic        illegal_op;

    exec_stage_mp #(.DATA_W(32), .REG_W(5), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .dst_in(dst_in), .src1(src1), .src2(src2),
        .src1_reg(src1_reg), .src2_reg(src2_reg),
        .bp_valid(bp_valid), .bp_reg(bp_reg), .bp_data(bp_data),
        .bpm_valid(bpm_valid), .bpm_reg(bpm_reg), .bpm_data(bpm_data),
        .out_valid(out_valid), .result(result), .dst_out(dst_out),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: outputs scheduled by cycle number, stall until free_at.
    int          t = 0;
    int          free_at = 0;
    logic [31:0] m_res = '0;
    logic [4:0]  m_dst = '0;
    logic [31:0] s_res [int];
    logic [4:0]  s_dst [int];
    bit          s_ill [int];

    typedef struct {
        logic [6:0]  op;
        logic [31:0] s1, s2;
        logic [4:0]  r1, r2, dst;
        logic        bv;
        logic [4:0]  br;
        logic [31:0] bd;
        logic        mv;
        logic [4:0]  mr;
        logic [31:0] md;
        logic        ev;
        logic [31:0] er;
        logic        eill;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, t, act, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] raw);
        if (r != 0 && bp_valid && bp_reg == r) return bp_data;
        if (r != 0 && bpm_valid && bpm_reg == r) return bpm_data;
        return raw;
    endfunction

    task automatic sched(input int at, input logic [31:0] r, input logic [4:0] d, input bit ill);
        s_res[at] = r;
        s_dst[at] = d;
        s_ill[at] = ill;
    endtask

    task automatic model_reset();
        s_res.delete();
        s_dst.delete();
        s_ill.delete();
        m_res   = '0;
        m_dst   = '0;
        free_at = t;
    endtask

    task automatic idle_inputs();
        in_valid = 0; opcode = 7'h3F; dst_in = 0; src1 = 0; src2 = 0;
        src1_reg = 0; src2_reg = 0; bp_valid = 0; bp_reg = 0; bp_data = 0;
        bpm_valid = 0; bpm_reg = 0; bpm_data = 0;
    endtask

    // Compare this cycle's outputs with the model, account for any transfer, advance.
    task automatic run_cycle();
        logic        ov_e, ill_e;
        logic [31:0] a, b;
        logic [63:0] prod;
        ov_e = 0;
        ill_e = 0;
        if (s_res.exists(t)) begin
            ov_e  = 1;
            ill_e = s_ill[t];
            m_res = s_res[t];
            m_dst = s_dst[t];
            s_res.delete(t);
            s_dst.delete(t);
            s_ill.delete(t);
        end
        chk("in_ready", in_ready, (t >= free_at));
        chk("out_valid", out_valid, ov_e);
        chk("result", result, m_res);
        chk("dst_out", dst_out, m_dst);
        chk("illegal_op", illegal_op, ill_e);
        if (in_valid && t >= free_at) begin
            a = fwd(src1_reg, src1);
            b = fwd(src2_reg, src2);
            case (opcode)
                7'h00: sched(t + 1, a + b, dst_in, 0);
                7'h01: sched(t + 1, a - b, dst_in, 0);
                7'h02: begin
                    prod = {32'd0, a} * {32'd0, b};
                    sched(t + MUL_LAT, prod[31:0], dst_in, 0);
                    free_at = t + MUL_LAT;
                end
                7'h3F: ;
                default: sched(t + 1, 32'hFFFF_FFFF, dst_in, 1);
            endcase
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    function automatic vec_t mk(input logic [6:0] op, input logic [31:0] s1, s2,
                                input logic [4:0] r1, r2, dst,
                                input logic bv, input logic [4:0] br, input logic [31:0] bd,
                                input logic mv, input logic [4:0] mr, input logic [31:0] md,
                                input logic ev, input logic [31:0] er, input logic eill);
        vec_t v;
        v.op = op; v.s1 = s1; v.s2 = s2; v.r1 = r1; v.r2 = r2; v.dst = dst;
        v.bv = bv; v.br = br; v.bd = bd; v.mv = mv; v.mr = mr; v.md = md;
        v.ev = ev; v.er = er; v.eill = eill;
        return v;
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        idle_inputs();
        rst_n = 0;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_dst_out", dst_out, 0);
        chk("rst_illegal", illegal_op, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1;
        @(posedge clk);
        #1;
        t = 0;
        model_reset();

        // op, s1, s2, r1, r2, dst, bv, br, bd, mv, mr, md, ev, er, eill
        vecs.push_back(mk(7'h00, 5, 7, 1, 2, 3, 0, 0, 0, 0, 0, 0, 1, 12, 0));
        vecs.push_back(mk(7'h01, 0, 1, 1, 2, 4, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0));
        vecs.push_back(mk(7'h00, 32'hFFFF_FFFF, 2, 1, 2, 5, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(7'h00, 1, 0, 4, 0, 6, 1, 4, 32'hAA, 1, 4, 32'hBB, 1, 32'hAA, 0));
        vecs.push_back(mk(7'h00, 1, 0, 4, 0, 6, 0, 4, 32'hAA, 1, 4, 32'hBB, 1, 32'hBB, 0));
        vecs.push_back(mk(7'h00, 32'h10, 0, 0, 0, 7, 1, 0, 32'hAA, 1, 0, 32'hBB, 1, 32'h10, 0));
        vecs.push_back(mk(7'h00, 1, 2, 1, 7, 8, 1, 7, 32'h100, 1, 9, 32'h55, 1, 32'h101, 0));
        vecs.push_back(mk(7'h01, 50, 8, 3, 9, 9, 0, 3, 32'h77, 0, 9, 32'h66, 1, 42, 0));
        vecs.push_back(mk(7'h01, 1, 2, 3, 9, 10, 1, 3, 32'h30, 1, 9, 32'h10, 1, 32'h20, 0));
        vecs.push_back(mk(7'h15, 1, 2, 1, 2, 11, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 1));
        vecs.push_back(mk(7'h3F, 1, 2, 1, 2, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            in_valid = 1; opcode = vecs[i].op; dst_in = vecs[i].dst;
            src1 = vecs[i].s1; src2 = vecs[i].s2;
            src1_reg = vecs[i].r1; src2_reg = vecs[i].r2;
            bp_valid = vecs[i].bv; bp_reg = vecs[i].br; bp_data = vecs[i].bd;
            bpm_valid = vecs[i].mv; bpm_reg = vecs[i].mr; bpm_data = vecs[i].md;
            run_cycle();
            idle_inputs();
            chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].ev);
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d_result", i), result, vecs[i].er);
                chk($sformatf("vec%0d_dst_out", i), dst_out, vecs[i].dst);
                chk($sformatf("vec%0d_illegal", i), illegal_op, vecs[i].eill);
            end
            run_cycle();
        end

        // MUL 3*4 with an ADD held behind it.
        in_valid = 1; opcode = 7'h02; src1 = 3; src2 = 4; src1_reg = 1; src2_reg = 2; dst_in = 13;
        run_cycle();
        opcode = 7'h00; src1 = 20; src2 = 22; dst_in = 14;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            run_cycle();
            n++;
        end
        chk("mul_stall_cycles", n, MUL_LAT - 1);
        chk("mul_out_valid", out_valid, 1);
        chk("mul_result", result, 12);
        chk("mul_dst_out", dst_out, 13);
        run_cycle();
        idle_inputs();
        chk("held_add_valid", out_valid, 1);
        chk("held_add_result", result, 42);
        chk("held_add_dst", dst_out, 14);
        run_cycle();

        // Back-to-back multiplies: second accepted in the completion cycle.
        in_valid = 1; opcode = 7'h02; src1 = 32'h1_0001; src2 = 32'h1_0000; src1_reg = 1; src2_reg = 2; dst_in = 15;
        run_cycle();
        src1 = 6; src2 = 7; dst_in = 16;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            run_cycle();
            n++;
        end
        chk("mul_wrap_result", result, 32'h0001_0000);
        run_cycle();
        idle_inputs();
        for (int i = 0; i < MUL_LAT; i++) run_cycle();
        chk("mul2_result", result, 42);

        // Reset two cycles into a multiply.
        in_valid = 1; opcode = 7'h02; src1 = 9; src2 = 9; src1_reg = 1; src2_reg = 2; dst_in = 17;
        run_cycle();
        idle_inputs();
        run_cycle();
        #2 rst_n = 0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_result", result, 0);
        chk("midrst_dst_out", dst_out, 0);
        chk("midrst_in_ready", in_ready, 1);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1;
        @(posedge clk);
        #1;
        model_reset();
        for (int i = 0; i < MUL_LAT + 3; i++) run_cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            int sel;
            in_valid = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: opcode = 7'h00;
                3, 4:    opcode = 7'h01;
                5, 6:    opcode = 7'h02;
                7:       opcode = 7'h3F;
                8:       opcode = 7'($urandom_range(3, 62));
                default: opcode = 7'($urandom_range(64, 127));
            endcase
            dst_in   = 5'($urandom);
            src1     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
            src2     = $urandom;
            src1_reg = 5'($urandom_range(0, 3));
            src2_reg = 5'($urandom_range(0, 3));
            bp_valid = $urandom_range(0, 1);
            bp_reg   = 5'($urandom_range(0, 3));
            bp_data  = $urandom;
            bpm_valid = $urandom_range(0, 1);
            bpm_reg  = 5'($urandom_range(0, 3));
            bpm_data = $urandom;
            run_cycle();
        end
        idle_inputs();
        for (int i = 0; i < MUL_LAT + 2; i++) run_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
